// File: rtl/div_arbiter_if.sv
// Request/response and divider-side signals of the shared-divider arbiter.
// slave is the arbiter's view; master is the environment (requesters plus divider).
interface div_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_dividend;
  logic [NUM_REQ*32-1:0] req_divisor;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_quotient;
  logic [31:0]           rsp_remainder;
  logic                  rsp_dz;
  logic                  div_start;
  logic [31:0]           div_dividend;
  logic [31:0]           div_divisor;
  logic                  div_busy;
  logic [31:0]           div_quotient;
  logic [31:0]           div_remainder;

  modport slave (
    input  req_valid, req_dividend, req_divisor, div_busy, div_quotient, div_remainder,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dz,
           div_start, div_dividend, div_divisor
  );

  modport master (
    output req_valid, req_dividend, req_divisor, div_busy, div_quotient, div_remainder,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dz,
           div_start, div_dividend, div_divisor
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative unsigned divider among NUM_REQ requesters.
// Divide-by-zero requests bypass the divider: quotient all-ones, remainder = dividend.
module div_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input logic          clk,
  input logic          rst,
  div_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, RUN, CAPT, DZ} state_e;

  state_e             state_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    cur_id_q;
  logic [31:0]        op_a_q;
  logic [31:0]        op_b_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic               div_start_q;
  logic               rsp_valid_q;
  logic               rsp_dz_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [31:0]        rsp_quotient_q;
  logic [31:0]        rsp_remainder_q;

  logic               found_d;
  logic [ID_W-1:0]    win_d;
  logic [ID_W-1:0]    rr_ptr_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [31:0]        win_a_d;
  logic [31:0]        win_b_d;

  // Winner: first valid requester at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int idx;
    idx     = 0;
    found_d = 1'b0;
    win_d   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found_d && (i == idx) && bus.req_valid[i]) begin
          found_d = 1'b1;
          win_d   = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    grant_d = '0;
    win_a_d = '0;
    win_b_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found_d && (win_d == ID_W'(i))) begin
        grant_d[i] = 1'b1;
        win_a_d    = bus.req_dividend[32*i +: 32];
        win_b_d    = bus.req_divisor[32*i +: 32];
      end
    end
    rr_ptr_d = (win_d == ID_W'(NUM_REQ - 1)) ? '0 : win_d + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      cur_id_q        <= '0;
      op_a_q          <= '0;
      op_b_q          <= '0;
      req_ready_q     <= '0;
      div_start_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_dz_q        <= 1'b0;
      rsp_id_q        <= '0;
      rsp_quotient_q  <= '0;
      rsp_remainder_q <= '0;
    end else begin
      req_ready_q <= '0;
      div_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            req_ready_q <= grant_d;
            op_a_q      <= win_a_d;
            op_b_q      <= win_b_d;
            cur_id_q    <= win_d;
            rr_ptr_q    <= rr_ptr_d;
            if (win_b_d == 32'd0) begin
              state_q <= DZ;
            end else begin
              state_q     <= START;
              div_start_q <= 1'b1;
            end
          end
        end
        START: state_q <= RUN;
        // The response is registered on leaving RUN so rsp_valid coincides with CAPT.
        RUN: begin
          if (!bus.div_busy) begin
            rsp_quotient_q  <= bus.div_quotient;
            rsp_remainder_q <= bus.div_remainder;
            rsp_id_q        <= cur_id_q;
            rsp_dz_q        <= 1'b0;
            rsp_valid_q     <= 1'b1;
            state_q         <= CAPT;
          end
        end
        CAPT: state_q <= IDLE;
        DZ: begin
          rsp_quotient_q  <= 32'hFFFF_FFFF;
          rsp_remainder_q <= op_a_q;
          rsp_id_q        <= cur_id_q;
          rsp_dz_q        <= 1'b1;
          rsp_valid_q     <= 1'b1;
          state_q         <= CAPT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_quotient  = rsp_quotient_q;
  assign bus.rsp_remainder = rsp_remainder_q;
  assign bus.rsp_dz        = rsp_dz_q;
  assign bus.div_start     = div_start_q;
  assign bus.div_dividend  = op_a_q;
  assign bus.div_divisor   = op_b_q;
endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a 32-cycle behavioural divider and a response scoreboard.
module tb_div_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int LAT_DIV = 35;
  localparam int LAT_DZ  = 2;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     q;
    logic [31:0]     r;
    logic            dz;
    int              lat;
    int              starts;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  div_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Divider: busy for 32 cycles after start, results valid when busy drops.
  logic [31:0] dm_a;
  logic [31:0] dm_b;
  int          dm_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.div_busy      <= 1'b0;
      bus.div_quotient  <= '0;
      bus.div_remainder <= '0;
      dm_a              <= '0;
      dm_b              <= '0;
      dm_cnt            <= 0;
    end else if (bus.div_start) begin
      dm_a         <= bus.div_dividend;
      dm_b         <= bus.div_divisor;
      dm_cnt       <= 32;
      bus.div_busy <= 1'b1;
    end else if (dm_cnt == 1) begin
      dm_cnt            <= 0;
      bus.div_busy      <= 1'b0;
      bus.div_quotient  <= (dm_b == 0) ? 32'hFFFF_FFFF : dm_a / dm_b;
      bus.div_remainder <= (dm_b == 0) ? dm_a : dm_a % dm_b;
    end else if (dm_cnt > 1) begin
      dm_cnt <= dm_cnt - 1;
    end
  end

  exp_t               sb[$];
  int                 errors     = 0;
  int                 checks     = 0;
  int                 cyc        = 0;
  int                 grant_cyc  = 0;
  int                 start_cnt  = 0;
  int                 n_grants   = 0;
  int                 n_rsp      = 0;
  int                 req1_grant = 0;
  logic [NUM_REQ-1:0] sticky     = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
    chk({tag, "_rsp_quotient"}, bus.rsp_quotient, 32'd0);
    chk({tag, "_rsp_remainder"}, bus.rsp_remainder, 32'd0);
    chk({tag, "_rsp_dz"}, 32'(bus.rsp_dz), 32'd0);
    chk({tag, "_div_start"}, 32'(bus.div_start), 32'd0);
    chk({tag, "_div_dividend"}, bus.div_dividend, 32'd0);
    chk({tag, "_div_divisor"}, bus.div_divisor, 32'd0);
  endtask

  // One clock: sample at the falling edge, retire grants, score responses.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (bus.req_ready != '0) begin
      chk("ready_onehot", 32'($onehot(bus.req_ready)), 32'd1);
      grant_cyc = cyc;
      n_grants++;
      if (bus.req_ready[1]) req1_grant = n_grants;
      bus.req_valid = bus.req_valid & ~(bus.req_ready & ~sticky);
    end
    if (bus.div_start) start_cnt++;
    if (bus.rsp_valid) begin
      n_rsp++;
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        chk("rsp_quotient", bus.rsp_quotient, e.q);
        chk("rsp_remainder", bus.rsp_remainder, e.r);
        chk("rsp_dz", 32'(bus.rsp_dz), 32'(e.dz));
        chk("latency", 32'(cyc - grant_cyc + 1), 32'(e.lat));
        chk("div_start_count", 32'(start_cnt), 32'(e.starts));
        start_cnt = 0;
      end
    end
  endtask

  task automatic push_exp(input int id, input logic [31:0] q, input logic [31:0] r,
                          input logic dz, input int lat, input int starts);
    exp_t e;
    e.id = ID_W'(id); e.q = q; e.r = r; e.dz = dz; e.lat = lat; e.starts = starts;
    sb.push_back(e);
  endtask

  task automatic request(input int id, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i == id) begin
        bus.req_dividend[32*i +: 32] = a;
        bus.req_divisor[32*i +: 32]  = b;
      end
    end
    bus.req_valid = bus.req_valid | (NUM_REQ'(1) << id);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || bus.req_valid != '0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_grants(input int target, input int budget);
    int n = 0;
    while (n_grants < target && n < budget) begin
      tick();
      n++;
    end
    chk("grant_wait", 32'(n_grants), 32'(target));
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    start_cnt = 0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    int g0;
    int r0;
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    repeat (3) tick();
    chk_cleared("reset");
    rst = 1'b1;
    tick();

    // Single division on requester 0.
    push_exp(0, 32'd14, 32'd2, 1'b0, LAT_DIV, 1);
    request(0, 32'd100, 32'd7);
    drain(100);

    // All four at once right after reset: served 0,1,2,3.
    pulse_reset();
    push_exp(0, 32'd333, 32'd1, 1'b0, LAT_DIV, 1);
    push_exp(1, 32'd142, 32'd6, 1'b0, LAT_DIV, 1);
    push_exp(2, 32'd111, 32'd1, 1'b0, LAT_DIV, 1);
    push_exp(3, 32'd90, 32'd10, 1'b0, LAT_DIV, 1);
    request(0, 32'd1000, 32'd3);
    request(1, 32'd1000, 32'd7);
    request(2, 32'd1000, 32'd9);
    request(3, 32'd1000, 32'd11);
    drain(300);

    // Divide by zero bypasses the divider.
    push_exp(2, 32'hFFFF_FFFF, 32'd5, 1'b1, LAT_DZ, 0);
    request(2, 32'd5, 32'd0);
    drain(20);

    // Operand extremes.
    push_exp(1, 32'hFFFF_FFFF, 32'd0, 1'b0, LAT_DIV, 1);
    request(1, 32'hFFFF_FFFF, 32'd1);
    drain(100);
    push_exp(1, 32'd0, 32'd1, 1'b0, LAT_DIV, 1);
    request(1, 32'd1, 32'hFFFF_FFFF);
    drain(100);

    // Reset ten cycles into RUN aborts silently.
    request(1, 32'd100, 32'd3);
    wait_grants(n_grants + 1, 20);
    repeat (10) tick();
    rst = 1'b0;
    #1;
    chk_cleared("abort");
    start_cnt = 0;
    r0 = n_rsp;
    repeat (2) tick();
    rst = 1'b1;
    repeat (40) tick();
    chk("abort_no_rsp", 32'(n_rsp - r0), 32'd0);
    push_exp(0, 32'd4, 32'd1, 1'b0, LAT_DIV, 1);
    request(0, 32'd9, 32'd2);
    drain(100);

    // Requester 3 holds its request; requester 1 still gets the second grant.
    sticky = 4'b1000;
    g0 = n_grants;
    push_exp(3, 32'd10, 32'd0, 1'b0, LAT_DIV, 1);
    push_exp(1, 32'd7, 32'd1, 1'b0, LAT_DIV, 1);
    push_exp(3, 32'd10, 32'd0, 1'b0, LAT_DIV, 1);
    request(3, 32'd100, 32'd10);
    wait_grants(g0 + 1, 20);
    request(1, 32'd50, 32'd7);
    wait_grants(g0 + 3, 120);
    sticky = '0;
    bus.req_valid = '0;
    drain(100);
    chk("req1_grant_order", 32'(req1_grant - g0), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
